// File: rtl/bcd_disp_pkg.sv
// Shared constants and the nibble-to-segment decode for the BCD display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (common-anode display).
package bcd_disp_pkg;

    localparam int BCD_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Non-BCD nibbles (A-F) render as "E" so a corrupt sum is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational decode of one BCD nibble into an active-low segment pattern.
module bcd_seg_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import bcd_disp_pkg::*;

    // Pure table lookup; the scanner registers the result.
    always_comb begin
        seg = bcd_to_seg(nibble);
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Captures the BCD adder result into a shadow register, commits it to the
// display register only at frame boundaries (no torn frames), and scans an
// 8-digit common-anode seven-segment display with a guard cycle per slot,
// optional leading-zero blanking and an overflow decimal point on digit 7.
module bcd_display_scanner #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] S,
    input  logic        Cout,
    input  logic        LOAD,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        OVF
);
    import bcd_disp_pkg::*;

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DIGITS);
    localparam int SW = 4 * BCD_DIGITS + 1;

    logic [PW-1:0] p_r;
    logic [DW-1:0] d_r;
    logic [SW-1:0] shadow_r;
    logic [SW-1:0] display_r;
    logic          pending_r;

    logic          p_last_s;
    logic          d_last_s;
    logic          boundary_s;
    logic          commit_s;
    logic [PW-1:0] p_nxt_s;
    logic [DW-1:0] d_nxt_s;
    logic [7:0]    blank_s;
    logic [3:0]    nibble_s;
    logic [6:0]    seg_s;

    // Next scan position; outputs are registered against it so they line up
    // with the counters in the same cycle.
    always_comb begin
        p_last_s   = (p_r == PW'(PRESCALE - 1));
        d_last_s   = (d_r == DW'(DIGITS - 1));
        boundary_s = p_last_s && d_last_s;
        commit_s   = boundary_s && pending_r;
        if (p_last_s) begin
            p_nxt_s = {PW{1'b0}};
            if (d_last_s) begin
                d_nxt_s = {DW{1'b0}};
            end else begin
                d_nxt_s = d_r + DW'(1);
            end
        end else begin
            p_nxt_s = p_r + PW'(1);
            d_nxt_s = d_r;
        end
    end

    // Leading-zero mask: digit k blanks when it and every higher nibble is
    // exactly 0; digit 0 always shows so a zero sum still reads "0".
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_s    = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            zero_above = zero_above && (display_r[4*k +: 4] == 4'h0);
            blank_s[k] = (BLANK_LZ != 0) && (k != 0) && zero_above;
        end
    end

    // Nibble for the slot being entered.
    always_comb begin
        nibble_s = display_r[{d_nxt_s, 2'b00} +: 4];
    end

    bcd_seg_decoder u_dec (
        .nibble (nibble_s),
        .seg    (seg_s)
    );

    // Prescale and digit counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            p_r <= {PW{1'b0}};
            d_r <= {DW{1'b0}};
        end else begin
            p_r <= p_nxt_s;
            d_r <= d_nxt_s;
        end
    end

    // Capture into the shadow and commit to the display at frame boundaries;
    // a LOAD on the boundary cycle re-arms pending after the old value commits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            shadow_r  <= {SW{1'b0}};
            display_r <= {SW{1'b0}};
            pending_r <= 1'b0;
        end else begin
            if (commit_s) begin
                display_r <= shadow_r;
            end
            if (LOAD) begin
                shadow_r  <= {Cout, S};
                pending_r <= 1'b1;
            end else if (commit_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Registered display drive: first cycle of each slot is a dark guard
    // cycle to avoid ghosting while anode and segments change together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            AN  <= 8'hFF;
            SEG <= SEG_BLANK;
            DP  <= 1'b1;
            OVF <= 1'b0;
        end else begin
            if (p_nxt_s == {PW{1'b0}}) begin
                AN  <= 8'hFF;
                SEG <= SEG_BLANK;
                DP  <= 1'b1;
            end else begin
                AN  <= blank_s[d_nxt_s] ? 8'hFF : ~(8'h01 << d_nxt_s);
                SEG <= seg_s;
                DP  <= ~((d_nxt_s == DW'(DIGITS - 1)) && display_r[SW-1]);
            end
            OVF <= commit_s ? shadow_r[SW-1] : display_r[SW-1];
        end
    end

endmodule
